// File: rtl/fixed_point_divider.sv
// fixed_point_divider: sequential sign-magnitude restoring divider, y = a / b, one quotient bit per clock
// Word format [sign | q_m integer | q_n fraction]; quotient truncated toward zero.
// Ports:
//   clk_i, reset_i (async, active-low)
//   valid_in / ready_out  : operand handshake, a_in dividend, b_in divisor
//   valid_out / ready_in  : result handshake, y_out quotient
//   overflow_out          : quotient magnitude saturated to all ones
//   div_by_zero_out       : divisor magnitude was zero (+0 or -0)
module fixed_point_divider #(
   parameter int sign = 1,
   parameter int q_m  = 16,
   parameter int q_n  = 16
) (
   input  logic                      clk_i,
   input  logic                      reset_i,
   input  logic                      valid_in,
   output logic                      ready_out,
   input  logic [sign+q_m+q_n-1:0]   a_in,
   input  logic [sign+q_m+q_n-1:0]   b_in,
   output logic                      valid_out,
   input  logic                      ready_in,
   output logic [sign+q_m+q_n-1:0]   y_out,
   output logic                      overflow_out,
   output logic                      div_by_zero_out
);
   localparam int W    = sign + q_m + q_n;
   localparam int M    = q_m + q_n;
   localparam int ITER = q_m + 2 * q_n;
   localparam int CW   = $clog2(ITER);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t          state_q;
   logic [ITER-1:0] d_q;
   // only ITER-1 quotient bits need storing: the final step supplies the LSB
   logic [ITER-2:0] q_q;
   logic [ITER-1:0] q_d;
   // remainder stays below the divisor after every step, so M bits hold it;
   // the extra bit of the trial remainder lives only in r_sh
   logic [M-1:0]    r_q, r_d, b_q, a_mag, b_mag, mag_d;
   logic [M:0]      r_sh;
   logic [CW-1:0]   cnt_q;
   logic [W-1:0]    y_q, y_d;
   logic            s_q, s_in, ge, ovf_d, ovf_q, dbz_q;
   always_comb begin
      a_mag = a_in[M-1:0];
      b_mag = b_in[M-1:0];
      s_in  = (sign != 0) && (a_in[W-1] ^ b_in[W-1]);
      r_sh  = {r_q, d_q[ITER-1]};
      ge    = r_sh >= {1'b0, b_q};
      r_d   = ge ? M'(r_sh - {1'b0, b_q}) : r_sh[M-1:0];
      q_d   = {q_q, ge};
      ovf_d = |q_d[ITER-1:M];
      mag_d = ovf_d ? {M{1'b1}} : q_d[M-1:0];
      // sign only on a non-zero magnitude, so -0 is never produced
      y_d   = W'(mag_d) | (W'(s_q & |mag_d) << M);
   end
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= IDLE;
         d_q     <= '0;
         q_q     <= '0;
         r_q     <= '0;
         b_q     <= '0;
         s_q     <= 1'b0;
         cnt_q   <= '0;
         y_q     <= '0;
         ovf_q   <= 1'b0;
         dbz_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (valid_in) begin
               d_q   <= {a_mag, {q_n{1'b0}}};
               b_q   <= b_mag;
               s_q   <= s_in;
               r_q   <= '0;
               q_q   <= '0;
               cnt_q <= CW'(ITER - 1);
               if (b_mag == '0) begin
                  y_q     <= W'({M{1'b1}}) | (W'(s_in) << M);
                  ovf_q   <= 1'b0;
                  dbz_q   <= 1'b1;
                  state_q <= DONE;
               end else begin
                  state_q <= CALC;
               end
            end
            CALC: begin
               r_q <= r_d;
               q_q <= q_d[ITER-2:0];
               d_q <= d_q << 1;
               if (cnt_q == '0) begin
                  y_q     <= y_d;
                  ovf_q   <= ovf_d;
                  dbz_q   <= 1'b0;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            DONE: if (ready_in) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
   assign ready_out       = state_q == IDLE;
   assign valid_out       = state_q == DONE;
   assign y_out           = y_q;
   assign overflow_out    = ovf_q;
   assign div_by_zero_out = dbz_q;
endmodule

// File: tb/tb_fixed_point_divider.sv
// tb_fixed_point_divider: directed self-checking bench for fixed_point_divider at default parameters
module tb_fixed_point_divider;
   logic        clk_i = 1'b0;
   logic        reset_i = 1'b0;
   logic        valid_in = 1'b0;
   logic        ready_in = 1'b0;
   logic [32:0] a_in = '0;
   logic [32:0] b_in = '0;
   logic        ready_out, valid_out, overflow_out, div_by_zero_out;
   logic [32:0] y_out;
   int          n_vec = 0;
   int          n_err = 0;
   fixed_point_divider dut (
      .clk_i(clk_i), .reset_i(reset_i), .valid_in(valid_in), .ready_out(ready_out),
      .a_in(a_in), .b_in(b_in), .valid_out(valid_out), .ready_in(ready_in),
      .y_out(y_out), .overflow_out(overflow_out), .div_by_zero_out(div_by_zero_out)
   );
   always #5 clk_i = ~clk_i;
   task automatic chk(input string tag, input logic [32:0] obs, input logic [32:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic run(input string tag, input logic [32:0] a, input logic [32:0] b,
                      input logic [32:0] y, input logic ovf, input logic dbz,
                      input int lat_exp, input int hold);
      int lat;
      @(negedge clk_i);
      chk({tag, ".ready_idle"}, 33'(ready_out), 33'd1);
      a_in = a;
      b_in = b;
      valid_in = 1'b1;
      @(posedge clk_i);
      #1;
      valid_in = 1'b0;
      a_in = '0;
      b_in = '0;
      lat = 0;
      while (!valid_out && lat < 100) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
      chk({tag, ".latency"}, 33'(lat), 33'(lat_exp));
      @(negedge clk_i);
      chk({tag, ".y"}, y_out, y);
      chk({tag, ".ovf"}, 33'(overflow_out), 33'(ovf));
      chk({tag, ".dbz"}, 33'(div_by_zero_out), 33'(dbz));
      chk({tag, ".ready_busy"}, 33'(ready_out), 33'd0);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk_i);
         chk({tag, ".hold_y"}, y_out, y);
         chk({tag, ".hold_valid"}, 33'(valid_out), 33'd1);
         chk({tag, ".hold_ready"}, 33'(ready_out), 33'd0);
      end
      // offer a new operand during the handoff edge; it must not be taken
      ready_in = 1'b1;
      valid_in = 1'b1;
      a_in = 33'h0_0001_0000;
      b_in = 33'h0_0003_0000;
      @(posedge clk_i);
      #1;
      ready_in = 1'b0;
      valid_in = 1'b0;
      chk({tag, ".handoff_valid"}, 33'(valid_out), 33'd0);
      chk({tag, ".handoff_ready"}, 33'(ready_out), 33'd1);
      chk({tag, ".keep_y"}, y_out, y);
   endtask
   initial begin
      logic seen;
      #12;
      chk("rst.valid", 33'(valid_out), 33'd0);
      chk("rst.y", y_out, 33'd0);
      chk("rst.ovf", 33'(overflow_out), 33'd0);
      chk("rst.dbz", 33'(div_by_zero_out), 33'd0);
      @(negedge clk_i);
      reset_i = 1'b1;
      @(negedge clk_i);
      chk("rst.ready", 33'(ready_out), 33'd1);
      run("t1_quarter_half",   33'h0_0000_4000, 33'h0_0000_8000, 33'h0_0000_8000, 0, 0, 48, 5);
      run("t2_neg_div",        33'h1_0002_4000, 33'h0_0001_8000, 33'h1_0001_8000, 0, 0, 48, 0);
      run("t2_neg_neg",        33'h1_0000_8000, 33'h1_0000_8000, 33'h0_0001_0000, 0, 0, 48, 0);
      run("t2_pos_neg",        33'h0_0000_4000, 33'h1_0000_8000, 33'h1_0000_8000, 0, 0, 48, 0);
      run("t3_third",          33'h0_0001_0000, 33'h0_0003_0000, 33'h0_0000_5555, 0, 0, 48, 0);
      run("t3_negzero_negone", 33'h1_0000_0000, 33'h1_0001_0000, 33'h0_0000_0000, 0, 0, 48, 0);
      run("t3_negzero_posone", 33'h1_0000_0000, 33'h0_0001_0000, 33'h0_0000_0000, 0, 0, 48, 0);
      run("t4_div_negzero",    33'h0_0001_0000, 33'h1_0000_0000, 33'h1_FFFF_FFFF, 0, 1, 0, 2);
      run("t5_overflow",       33'h0_8000_0000, 33'h0_0000_0001, 33'h0_FFFF_FFFF, 1, 0, 48, 0);
      run("t5_max_by_one",     33'h1_FFFF_FFFF, 33'h0_0001_0000, 33'h1_FFFF_FFFF, 0, 0, 48, 0);
      // abort a division at CALC step 20 with an asynchronous reset
      @(negedge clk_i);
      a_in = 33'h0_0001_0000;
      b_in = 33'h0_0003_0000;
      valid_in = 1'b1;
      @(posedge clk_i);
      #1;
      valid_in = 1'b0;
      repeat (20) @(posedge clk_i);
      #2;
      reset_i = 1'b0;
      #1;
      chk("t6_abort.valid", 33'(valid_out), 33'd0);
      chk("t6_abort.y", y_out, 33'd0);
      @(negedge clk_i);
      reset_i = 1'b1;
      @(negedge clk_i);
      chk("t6_abort.ready", 33'(ready_out), 33'd1);
      seen = 1'b0;
      repeat (60) begin
         @(negedge clk_i);
         seen = seen | valid_out;
      end
      chk("t6_abort.silent", 33'(seen), 33'd0);
      run("t6_after_abort",    33'h0_0003_0000, 33'h0_0000_8000, 33'h0_0006_0000, 0, 0, 48, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
